// File: rtl/seg7_scan_driver.sv
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Time-multiplexed N-digit seven-segment display driver.
//                A packed hex word, the decimal-point requests and the
//                per-digit enables are captured into shadow registers on
//                'load'. Digits are then scanned one per refresh slot. Each
//                slot begins with anti-ghost blanking, during which every
//                anode is inactive.
//
//  Ports       : clk       - system clock
//                rst_n     - asynchronous active-low reset
//                value     - packed hex digits, digit k = value[4k+3:4k]
//                dp_in     - decimal point request per digit (1 = lit)
//                digit_en  - per-digit enable (0 = digit blank)
//                load      - one-cycle strobe that captures the three inputs above
//                segs      - segments a..g, active low, segs[0] = a
//                dp        - decimal point, active low
//                an        - digit enables, polarity set by AN_ACTIVE_LOW
//                scan_idx  - index of the digit currently being scanned
//
//  Options     : SEG7_LEADING_ZERO_BLANK_EN - when defined, leading zero
//                digits are suppressed. Digit 0 is never suppressed.
//
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan_driver #(
    parameter int NUM_DIGITS    = 4,
    parameter int SCAN_DIV      = 50000,
    parameter int BLANK_CYCLES  = 4,
    parameter int AN_ACTIVE_LOW = 1,
    // Derived widths; these are not intended to be overridden.
    parameter int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    output logic [0:6]              segs,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [IDX_W-1:0]        scan_idx
);

    localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [PRESC_W-1:0]    C_PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [PRESC_W-1:0]    C_BLANK_END  = PRESC_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]      C_IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] C_AN_OFF     = (AN_ACTIVE_LOW != 0) ?
                                                     {NUM_DIGITS{1'b1}} :
                                                     {NUM_DIGITS{1'b0}};

    // ------------------------------------------------------------------
    // Shadow registers. The display reads only these registers, so a
    // change on the inputs can never tear a frame.
    // ------------------------------------------------------------------
    logic [4*NUM_DIGITS-1:0] r_value;
    logic [NUM_DIGITS-1:0]   r_dp_req;
    logic [NUM_DIGITS-1:0]   r_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value  <= '0;
            r_dp_req <= '0;
            r_en     <= '0;
        end else if (load) begin
            r_value  <= value;
            r_dp_req <= dp_in;
            r_en     <= digit_en;
        end
    end

    // ------------------------------------------------------------------
    // Slot prescaler and scan index
    // ------------------------------------------------------------------
    logic [PRESC_W-1:0] r_presc;
    logic [IDX_W-1:0]   r_scan_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc    <= '0;
            r_scan_idx <= '0;
        end else if (r_presc == C_PRESC_LAST) begin
            r_presc <= '0;
            // With a single digit, C_IDX_LAST is 0, so the index stays at 0.
            if (r_scan_idx == C_IDX_LAST) begin
                r_scan_idx <= '0;
            end else begin
                r_scan_idx <= r_scan_idx + IDX_W'(1);
            end
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    assign scan_idx = r_scan_idx;

    // ------------------------------------------------------------------
    // Leading-zero detection: digit k is suppressed when it and every
    // higher digit are zero. Digit 0 is never suppressed.
    // ------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] w_lz;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    assign w_lz[0] = 1'b0;
    for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_lz
        assign w_lz[k] = (r_value[4*NUM_DIGITS-1:4*k] == '0);
    end
`else
    assign w_lz = '0;
`endif

    // ------------------------------------------------------------------
    // Select the attributes of the digit currently being scanned
    // ------------------------------------------------------------------
    logic [3:0]            w_nib;
    logic                  w_cur_dp;
    logic                  w_cur_en;
    logic                  w_cur_lz;
    logic [NUM_DIGITS-1:0] w_onehot;

    always_comb begin
        w_nib    = '0;
        w_cur_dp = 1'b0;
        w_cur_en = 1'b0;
        w_cur_lz = 1'b0;
        w_onehot = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_scan_idx == IDX_W'(k)) begin
                w_nib       = r_value[4*k +: 4];
                w_cur_dp    = r_dp_req[k];
                w_cur_en    = r_en[k];
                w_cur_lz    = w_lz[k];
                w_onehot[k] = 1'b1;
            end
        end
    end

    // Hex-to-segment decoder. Bit 6 is segment a and bit 0 is segment g.
    // Each bit is 1 for a lit segment.
    logic [6:0] w_code;

    always_comb begin
        w_code = 7'h00;
        case (w_nib)
            4'h0:    w_code = 7'h7e;
            4'h1:    w_code = 7'h30;
            4'h2:    w_code = 7'h6d;
            4'h3:    w_code = 7'h79;
            4'h4:    w_code = 7'h33;
            4'h5:    w_code = 7'h5b;
            4'h6:    w_code = 7'h5f;
            4'h7:    w_code = 7'h70;
            4'h8:    w_code = 7'h7f;
            4'h9:    w_code = 7'h7b;
            4'ha:    w_code = 7'h77;
            4'hb:    w_code = 7'h1f;
            4'hc:    w_code = 7'h4e;
            4'hd:    w_code = 7'h3d;
            4'he:    w_code = 7'h4f;
            default: w_code = 7'h47;
        endcase
    end

    logic                  w_blank;
    logic [NUM_DIGITS-1:0] w_an_on;

    assign w_blank = (r_presc < C_BLANK_END);
    assign w_an_on = (AN_ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;

    // ------------------------------------------------------------------
    // Registered outputs. Segments, dp and anodes all come from the same
    // state, so they change together. Each slot opens with a blank
    // period, so a load that lands on a slot boundary is never visible
    // while an anode is on.
    // ------------------------------------------------------------------
    logic [6:0]            r_segs;
    logic                  r_dp;
    logic [NUM_DIGITS-1:0] r_an;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_segs <= 7'h7f;
            r_dp   <= 1'b1;
            r_an   <= C_AN_OFF;
        end else if (!w_cur_en) begin
            r_segs <= 7'h7f;
            r_dp   <= 1'b1;
            r_an   <= C_AN_OFF;
        end else if (w_cur_lz) begin
            // A suppressed digit can still show its decimal point. In that
            // case the anode must be driven for the decimal point to light.
            r_segs <= 7'h7f;
            r_dp   <= ~w_cur_dp;
            r_an   <= (w_cur_dp && !w_blank) ? w_an_on : C_AN_OFF;
        end else begin
            r_segs <= ~w_code;
            r_dp   <= ~w_cur_dp;
            r_an   <= w_blank ? C_AN_OFF : w_an_on;
        end
    end

    // segs is declared [0:6], so segs[0] takes the MSB of r_segs (segment a).
    assign segs = r_segs;
    assign dp   = r_dp;
    assign an   = r_an;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none

module tb_seg7_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = '0;
    logic        load = 1'b0;
    logic [0:6]  segs;
    logic        dp;
    logic [3:0]  an;
    logic [1:0]  scan_idx;

    int checks = 0;
    int errors = 0;

    seg7_scan_driver #(
        .NUM_DIGITS   (N),
        .SCAN_DIV     (DIV),
        .BLANK_CYCLES (BLANK),
        .AN_ACTIVE_LOW(1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .value   (value),
        .dp_in   (dp_in),
        .digit_en(digit_en),
        .load    (load),
        .segs    (segs),
        .dp      (dp),
        .an      (an),
        .scan_idx(scan_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Lit segments a..g for each hex digit, with a as the MSB.
    function automatic logic [6:0] lit(input int n);
        case (n)
            0: return 7'h7e;   1: return 7'h30;   2: return 7'h6d;   3: return 7'h79;
            4: return 7'h33;   5: return 7'h5b;   6: return 7'h5f;   7: return 7'h70;
            8: return 7'h7f;   9: return 7'h7b;  10: return 7'h77;  11: return 7'h1f;
           12: return 7'h4e;  13: return 7'h3d;  14: return 7'h4f;  default: return 7'h47;
        endcase
    endfunction

    // Behavioural model. Outputs seen after an edge reflect the slot
    // position and shadow contents just before that edge.
    int          m_presc = 0;
    int          m_idx   = 0;
    logic [15:0] m_val   = '0;
    logic [3:0]  m_dp    = '0;
    logic [3:0]  m_en    = '0;
    logic [6:0]  e_segs  = 7'h7f;
    logic        e_dp    = 1'b1;
    logic [3:0]  e_an    = 4'hf;
    int          e_idx   = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_presc = 0; m_idx = 0; m_val = '0; m_dp = '0; m_en = '0;
            e_segs = 7'h7f; e_dp = 1'b1; e_an = 4'hf; e_idx = 0;
        end else begin
            int  nib;
            bit  supp;
            bit  blank;
            nib   = int'((m_val >> (4 * m_idx)) & 16'hf);
            blank = (m_presc < BLANK);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            supp  = (m_idx != 0) && ((m_val >> (4 * m_idx)) == 16'h0);
`else
            supp  = 1'b0;
`endif
            if (!m_en[m_idx]) begin
                e_segs = 7'h7f; e_dp = 1'b1; e_an = 4'hf;
            end else begin
                e_dp   = ~m_dp[m_idx];
                e_segs = supp ? 7'h7f : ~lit(nib);
                if (blank || (supp && !m_dp[m_idx])) e_an = 4'hf;
                else e_an = ~(4'b0001 << m_idx);
            end
            if (load) begin
                m_val = value; m_dp = dp_in; m_en = digit_en;
            end
            m_presc = (m_presc + 1) % DIV;
            if (m_presc == 0) m_idx = (m_idx + 1) % N;
            e_idx = m_idx;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        chk("model_segs", 32'(segs), 32'(e_segs));
        chk("model_dp", 32'(dp), 32'(e_dp));
        chk("model_an", 32'(an), 32'(e_an));
        chk("model_idx", 32'(scan_idx), 32'(e_idx));
    end

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
        @(negedge clk);
        value = v; dp_in = d; digit_en = e; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Waits until 'an' equals the target. Returns at a negedge.
    task automatic wait_an(input logic [3:0] target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (an == target) begin ok = 1'b1; break; end
        end
        if (!ok) chk("wait_an_timeout", 32'(an), 32'(target));
    endtask

    // Waits until the model is at the given slot index and prescaler value.
    task automatic wait_pos(input int idx, input int pr, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (m_idx == idx && m_presc == pr) begin ok = 1'b1; break; end
        end
        if (!ok) chk("wait_pos_timeout", 32'(m_presc), 32'(pr));
    endtask

    logic [3:0] t_an[4]   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] t_seg[4]  = '{7'h38, 7'h06, 7'h08, 7'h4f};
    logic       t_dp[4]   = '{1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        bit ok;
        int cnt;
        int prev;

        // Reset behaviour
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_segs", 32'(segs), 32'h7f);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_an", 32'(an), 32'hf);
        chk("rst_idx", 32'(scan_idx), 32'h0);
        rst_n = 1'b1;
        value = 16'h0000; digit_en = 4'hf; dp_in = 4'h0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("rel_blank1", 32'(an), 32'hf);
        @(negedge clk);
        chk("rel_blank2", 32'(an), 32'hf);
        @(negedge clk);
        chk("rel_an_first", 32'(an), 32'he);
        chk("rel_segs_zero", 32'(segs), 32'h01);

        // Full frame showing 16'h1A3F
        do_load(16'h1a3f, 4'b0100, 4'hf);
        for (int k = 0; k < 4; k++) begin
            wait_an(t_an[k], ok);
            if (ok) begin
                chk("frame_segs", 32'(segs), 32'(t_seg[k]));
                chk("frame_dp", 32'(dp), 32'(t_dp[k]));
            end
        end

        // Load in the middle of a slot
        do_load(16'h0000, 4'h0, 4'hf);
        wait_pos(1, 5, ok);
        if (ok) begin
            value = 16'hffff; load = 1'b1;
            @(negedge clk);
            load = 1'b0;
            chk("midload_old", 32'(segs), 32'h01);
            @(negedge clk);
            chk("midload_new", 32'(segs), 32'h38);
            chk("midload_an", 32'(an), 32'hd);
        end

        // Disabled digits stay dark for the whole slot
        do_load(16'h8888, 4'h0, 4'b0101);
        wait_an(4'b1110, ok);
        if (ok) chk("en_d0_segs", 32'(segs), 32'h00);
        wait_an(4'b1011, ok);
        if (ok) chk("en_d2_segs", 32'(segs), 32'h00);
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (an == 4'b1101 || an == 4'b0111) cnt++;
        end
        chk("en_disabled_never_on", 32'(cnt), 32'h0);

        // Scan index wrap over three frames
        wait_pos(0, 1, ok);
        cnt = 0; prev = int'(scan_idx);
        for (int i = 0; i < 3 * N * DIV; i++) begin
            @(negedge clk);
            if (prev == 3 && scan_idx == 2'd0) cnt++;
            prev = int'(scan_idx);
        end
        chk("wrap_count", 32'(cnt), 32'h3);

        // Asynchronous reset in the middle of a slot
        wait_pos(2, 3, ok);
        #2 rst_n = 1'b0;
        #1;
        chk("async_segs", 32'(segs), 32'h7f);
        chk("async_dp", 32'(dp), 32'h1);
        chk("async_an", 32'(an), 32'hf);
        chk("async_idx", 32'(scan_idx), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("restart_idx", 32'(scan_idx), 32'h0);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
        do_load(16'h0040, 4'h0, 4'hf);
        wait_an(4'b1101, ok);
        if (ok) chk("lz_d1_segs", 32'(segs), 32'h4c);
        wait_an(4'b1110, ok);
        if (ok) chk("lz_d0_segs", 32'(segs), 32'h01);
        do_load(16'h0000, 4'h0, 4'hf);
        wait_an(4'b1110, ok);
        if (ok) chk("lz_zero_d0", 32'(segs), 32'h01);
`endif

        repeat (2 * N * DIV) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
